// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight,
// and hands {pc, inst} to decode through a one-entry registered slot.
module if_fetch #(
  parameter logic [63:0] PC_START = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_WAIT_DROP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [63:0] pc;
  logic [63:0] pc_n;
  logic [63:0] req_pc;
  logic [63:0] req_pc_n;
  logic        if_valid_n;
  logic [63:0] if_pc_n;
  logic [31:0] if_inst_n;
  logic [63:0] fetch_cnt_n;
  logic        req_fire;
  logic        drain;

  // Only request when the slot is free or leaving, so a response always has room.
  assign imem_req_valid = !rst && (state == S_REQ) && (!if_valid || if_ready);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign drain          = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      pc        <= {PC_START[63:2], 2'b00};
      req_pc    <= {PC_START[63:2], 2'b00};
      if_valid  <= 1'b0;
      if_pc     <= 64'd0;
      if_inst   <= 32'd0;
      fetch_cnt <= 64'd0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_pc    <= req_pc_n;
      if_valid  <= if_valid_n;
      if_pc     <= if_pc_n;
      if_inst   <= if_inst_n;
      fetch_cnt <= fetch_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_pc_n    = req_pc;
    if_valid_n  = if_valid;
    if_pc_n     = if_pc;
    if_inst_n   = if_inst;
    fetch_cnt_n = fetch_cnt;

    if (drain) begin
      if_valid_n = 1'b0;
      if (!redirect_valid) begin
        fetch_cnt_n = fetch_cnt + 64'd1;
      end
    end

    case (state)
      S_REQ: begin
        if (req_fire) begin
          req_pc_n = pc;
          state_n  = redirect_valid ? S_WAIT_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          state_n = S_REQ;
          if (!redirect_valid) begin
            if_valid_n = 1'b1;
            if_pc_n    = req_pc;
            if_inst_n  = imem_resp_data;
            pc_n       = req_pc + 64'd4;
          end
        end else if (redirect_valid) begin
          state_n = S_WAIT_DROP;
        end
      end
      S_WAIT_DROP: begin
        if (imem_resp_valid) begin
          state_n = S_REQ;
        end
      end
      default: begin
        state_n = S_REQ;
      end
    endcase

    // A redirect wins over every other update: new target, slot flushed.
    if (redirect_valid) begin
      pc_n       = {redirect_pc[63:2], 2'b00};
      if_valid_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: scoreboard of expected {pc, inst} deliveries,
// immediate assertions at every comparison point.
module tb_if_fetch;

  localparam logic [63:0] PC_START = 64'h8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } deliv_t;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic [63:0] fetch_cnt;

  deliv_t      sb[$];
  int          tests_run;
  int          tests_failed;
  logic [63:0] model_cnt;
  logic        req_valid_s;
  logic        req_fire_s;
  logic [63:0] req_addr_s;
  logic [63:0] last_addr;
  int          idle;

  if_fetch #(.PC_START(PC_START)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .fetch_cnt       (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [63:0] rpc, input logic rq_rdy,
                               input logic rsp_v, input logic [31:0] rsp_d, input logic dec_rdy);
    redirect_valid  = rv;
    redirect_pc     = rpc;
    imem_req_ready  = rq_rdy;
    imem_resp_valid = rsp_v;
    imem_resp_data  = rsp_d;
    if_ready        = dec_rdy;
  endtask

  // One cycle: sample just after inputs settle, score the slot, advance to the next falling edge.
  task automatic tick();
    deliv_t e;
    #1;
    req_valid_s = imem_req_valid;
    req_fire_s  = imem_req_valid && imem_req_ready;
    req_addr_s  = imem_req_addr;
    if (if_valid && redirect_valid && !rst) begin
      if (sb.size() > 0) e = sb.pop_front();
    end else if (if_valid && if_ready && !rst) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $error("[TB] FAIL unexpected_delivery: observed pc=%h expected no delivery", if_pc);
      end else begin
        e = sb.pop_front();
        checkOutput("deliver_pc", if_pc, e.pc);
        checkOutput("deliver_inst", 64'(if_inst), 64'(e.inst));
        model_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [63:0] exp_addr);
    idle = 0;
    tick();
    while (!req_fire_s && idle < 20) begin
      idle++;
      tick();
    end
    checkOutput("req_fire", 64'(req_fire_s), 64'd1);
    checkOutput("req_addr", req_addr_s, exp_addr);
    last_addr = req_addr_s;
  endtask

  task automatic respond(input int k, input logic [31:0] data, input logic deliver);
    for (int i = 1; i < k; i++) tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    if (deliver) sb.push_back({last_addr, data});
    tick();
    imem_resp_valid = 1'b0;
    if (deliver) begin
      checkOutput("slot_valid", 64'(if_valid), 64'd1);
      checkOutput("slot_pc", if_pc, last_addr);
    end
  endtask

  task automatic fetch(input logic [63:0] exp_addr, input int k, input logic [31:0] data);
    issue(exp_addr);
    checkOutput("req_idle", 64'(idle), 64'd0);
    respond(k, data, 1'b1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_cnt    = 64'd0;
    last_addr    = 64'd0;
    rst          = 1'b1;
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 32'd0, 1'b1);

    // Reset values
    tick();
    tick();
    checkOutput("rst_req_valid", 64'(req_valid_s), 64'd0);
    checkOutput("rst_if_valid", 64'(if_valid), 64'd0);
    checkOutput("rst_if_pc", if_pc, 64'd0);
    checkOutput("rst_if_inst", 64'(if_inst), 64'd0);
    checkOutput("rst_fetch_cnt", fetch_cnt, 64'd0);

    // Back-to-back zero-wait fetches
    rst = 1'b0;
    fetch(64'h8000_0000, 1, 32'h0000_0013);
    fetch(64'h8000_0004, 1, 32'h0000_0013);
    fetch(64'h8000_0008, 1, 32'h0000_0013);
    checkOutput("cnt_before_drain", fetch_cnt, 64'd2);

    // Decode stall: slot holds, no request
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_req_valid", 64'(req_valid_s), 64'd0);
      checkOutput("stall_pc", if_pc, 64'h8000_0008);
    end
    checkOutput("stall_inst", 64'(if_inst), 64'h13);
    checkOutput("stall_cnt", fetch_cnt, 64'd2);
    if_ready = 1'b1;
    fetch(64'h8000_000C, 1, 32'h0020_0113);
    checkOutput("cnt_after_three", fetch_cnt, 64'd3);

    // Redirect while waiting on a slow response
    issue(64'h8000_0010);
    applyStimulus(1'b1, 64'h8000_0100, 1'b1, 1'b0, 32'd0, 1'b1);
    tick();
    redirect_valid = 1'b0;
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    checkOutput("stale_dropped", 64'(if_valid), 64'd0);
    fetch(64'h8000_0100, 1, 32'h0010_0093);

    // Redirect with handshake and drain in the same cycle, misaligned target
    applyStimulus(1'b1, 64'h8000_0106, 1'b1, 1'b0, 32'd0, 1'b1);
    tick();
    redirect_valid = 1'b0;
    checkOutput("coinc_fire", 64'(req_fire_s), 64'd1);
    checkOutput("coinc_addr", req_addr_s, 64'h8000_0104);
    checkOutput("coinc_flush", 64'(if_valid), 64'd0);
    checkOutput("coinc_cnt", fetch_cnt, model_cnt);
    checkOutput("coinc_cnt_abs", fetch_cnt, 64'd4);
    tick();
    checkOutput("drop_no_req", 64'(req_valid_s), 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0BAD_0BAD;
    tick();
    imem_resp_valid = 1'b0;
    checkOutput("drop_resp", 64'(if_valid), 64'd0);
    fetch(64'h8000_0104, 1, 32'h0030_0193);

    // PC wrap at the top of the address space
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h0040_0213);
    fetch(64'h0000_0000_0000_0000, 2, 32'h0050_0293);

    // Reset mid-transaction, late response ignored
    issue(64'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    model_cnt = 64'd0;
    checkOutput("mid_rst_valid", 64'(if_valid), 64'd0);
    checkOutput("mid_rst_pc", if_pc, 64'd0);
    checkOutput("mid_rst_inst", 64'(if_inst), 64'd0);
    checkOutput("mid_rst_cnt", fetch_cnt, 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 32'h1111_1111, 1'b1);
    tick();
    imem_resp_valid = 1'b0;
    checkOutput("post_rst_req_valid", 64'(req_valid_s), 64'd1);
    checkOutput("post_rst_req_addr", req_addr_s, PC_START);
    checkOutput("post_rst_ignored", 64'(if_valid), 64'd0);
    imem_req_ready = 1'b1;
    fetch(PC_START, 1, 32'h0060_0313);
    imem_req_ready = 1'b0;
    tick();
    checkOutput("final_cnt", fetch_cnt, 64'd1);
    checkOutput("final_model_cnt", fetch_cnt, model_cnt);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
